// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: PCSrc encodings, fetch FSM states, defaults.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_RST = 2'b11
    } pcsrc_e;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR   = 32'h0000_0000;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC mux: sequential, branch, jump or reset vector.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PC4,
    input  logic [31:0] ExtendOut,
    input  logic [25:0] Address,
    output logic [31:0] next_pc
);

    // The word offset is shifted left by two, so its top two bits fall off.
    logic unused_ext_hi;
    assign unused_ext_hi = &{1'b0, ExtendOut[31:30]};

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        next_pc = PC4;
        case (PCSrc)
            PCSRC_SEQ: next_pc = PC4;
            PCSRC_BR:  next_pc = PC4 + {ExtendOut[29:0], 2'b00};
            PCSRC_J:   next_pc = {PC4[31:28], Address, 2'b00};
            PCSRC_RST: next_pc = RESET_VECTOR;
            default:   next_pc = PC4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and instruction-fetch sequencer (BOOT/FETCH/WAIT/ISSUE/HALT).
// Optional wait-state watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ExtendOut,
    input  logic [25:0] Address,
    input  logic        redirect_valid,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        halted,
    output logic        fetch_err
);

    fetch_state_e state, state_next;
    logic [31:0]  redirect_pc;
    logic         fetching;
    logic         timeout;

    assign PC4       = PC + 32'd4;
    assign imem_addr = PC;
    assign fetching  = (state == FETCH) || (state == WAIT);

    next_pc_calc #(.RESET_VECTOR(RESET_VECTOR)) u_next_pc (
        .PCSrc     (PCSrc),
        .PC4       (PC4),
        .ExtendOut (ExtendOut),
        .Address   (Address),
        .next_pc   (redirect_pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // An ack in the final wait cycle still wins over the timeout.
    assign timeout = (state == WAIT) && !imem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == FETCH)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
            if (timeout)            fetch_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:    state_next = FETCH;
            FETCH:   state_next = imem_ack ? ISSUE : WAIT;
            WAIT: begin
                if (imem_ack)     state_next = ISSUE;
                else if (timeout) state_next = HALT;
            end
            ISSUE: begin
                if (!stall) state_next = halt ? HALT : FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state)
            FETCH, WAIT: imem_req    = 1'b1;
            ISSUE:       instr_valid = 1'b1;
            HALT:        halted      = 1'b1;
            default:     ;
        endcase
    end

    // Halt takes priority over redirect; a stalled issue holds PC and instr.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            PC    <= RESET_VECTOR;
            instr <= '0;
        end else begin
            if (fetching && imem_ack) instr <= imem_rdata;
            if (state == ISSUE && !stall && !halt)
                PC <= redirect_valid ? redirect_pc : PC4;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl; timeout cases run when FETCH_TIMEOUT_EN is defined.
module tb_pc_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [1:0]  PCSrc;
    logic [31:0] ExtendOut;
    logic [25:0] Address;
    logic        redirect_valid, stall, halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr, PC, PC4;
    logic        halted, fetch_err;

    pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .ExtendOut(ExtendOut), .Address(Address),
        .redirect_valid(redirect_valid), .stall(stall), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .PC(PC), .PC4(PC4),
        .halted(halted), .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_fetch[$];
    logic [31:0] exp_issue[$];

    int mem_wait   = 0;
    bit mem_enable = 1'b1;
    int req_cnt    = 0;
    int last_req_len = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after mem_wait request cycles; drives spurious acks while idle.
    always @(negedge CLK) begin
        if (imem_req && Reset) begin
            if (mem_enable && req_cnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = instr_of(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
            end
            req_cnt++;
        end else begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            req_cnt    = 0;
        end
    end

    // Monitor: pops expected fetch addresses and issued PCs as the DUT presents them.
    logic        prev_req = 1'b0, prev_valid = 1'b0, prev_ack_req = 1'b0;
    logic [31:0] cur_fetch = '0, cur_pc = '0;
    int          req_len = 0;

    always begin
        @(negedge CLK);
        #1;
        if (!Reset) begin
            prev_req = 1'b0; prev_valid = 1'b0; prev_ack_req = 1'b0; req_len = 0;
        end else begin
            if (imem_req) begin
                if (!prev_req) begin
                    if (exp_fetch.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
                    else begin
                        cur_fetch = exp_fetch.pop_front();
                        check("fetch_addr", imem_addr, cur_fetch);
                    end
                    req_len = 1;
                end else begin
                    check("fetch_addr_stable", imem_addr, cur_fetch);
                    req_len++;
                end
            end else if (prev_req) begin
                last_req_len = req_len;
            end
            if (prev_ack_req) check("ack_to_issue", instr_valid, 32'd1);
            if (instr_valid) begin
                if (!prev_valid) begin
                    if (exp_issue.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
                    else begin
                        cur_pc = exp_issue.pop_front();
                        check("issue_pc", PC, cur_pc);
                        check("issue_pc4", PC4, cur_pc + 32'd4);
                        check("issue_instr", instr, instr_of(cur_pc));
                    end
                end else begin
                    check("stall_pc", PC, cur_pc);
                    check("stall_instr", instr, instr_of(cur_pc));
                end
            end
            prev_req     = imem_req;
            prev_valid   = instr_valid;
            prev_ack_req = imem_ack && imem_req;
        end
    end

    task automatic expect_fetch(input logic [31:0] a);
        exp_fetch.push_back(a);
        exp_issue.push_back(a);
    endtask

    task automatic check_reset_vals();
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", instr_valid, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_halted", halted, 32'd0);
        check("rst_fetch_err", fetch_err, 32'd0);
        check("rst_pc", PC, 32'h0000_0000);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        exp_fetch.delete();
        exp_issue.delete();
        @(negedge CLK);
        #1;
        check_reset_vals();
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!instr_valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!instr_valid) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_issue(input logic rv, input logic [1:0] src, input logic [31:0] ext,
                            input logic [25:0] adr, input logic hlt, input int stall_n,
                            input logic [31:0] exp_next, input int next_wait);
        wait_issue();
        redirect_valid = rv; PCSrc = src; ExtendOut = ext; Address = adr; halt = hlt;
        stall = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            @(negedge CLK);
            #1;
            check("stall_no_req", imem_req, 32'd0);
            check("stall_valid", instr_valid, 32'd1);
        end
        stall    = 1'b0;
        mem_wait = next_wait;
        if (!hlt) expect_fetch(exp_next);
        @(negedge CLK);
        redirect_valid = 1'($urandom); halt = 1'($urandom); stall = 1'($urandom);
        PCSrc = 2'($urandom); ExtendOut = $urandom; Address = 26'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; PCSrc = 2'b00; ExtendOut = '0; Address = '0;
        redirect_valid = 1'b0; stall = 1'b0; halt = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge CLK);
        do_reset();
        expect_fetch(32'h0);

        // Zero-wait sequential run, then a 3-wait fetch at 0x10.
        do_issue(1'b0, 2'b00, 32'h0, 26'h0, 1'b0, 0, 32'h4, 0);
        do_issue(1'b0, 2'b00, 32'h0, 26'h0, 1'b0, 0, 32'h8, 0);
        check("gap_fetch", instr_valid, 32'd0);
        check("run_halted", halted, 32'd0);
        @(negedge CLK);
        check("gap_issue", instr_valid, 32'd1);
        do_issue(1'b0, 2'b00, 32'h0, 26'h0, 1'b0, 0, 32'hC, 0);
        do_issue(1'b0, 2'b00, 32'h0, 26'h0, 1'b0, 0, 32'h10, 3);
        wait_issue();
        #2;
        check("wait_req_len", 32'(last_req_len), 32'd4);

        // Redirects: jump, negative branch, jump, stalled branch, reset vector.
        do_issue(1'b1, 2'b10, 32'h0,         26'h0000040, 1'b0, 0, 32'h0000_0100, 0);
        do_issue(1'b1, 2'b01, 32'hFFFF_FFFE, 26'h1234567, 1'b0, 0, 32'h0000_00FC, 0);
        do_issue(1'b1, 2'b10, 32'h7777_7777, 26'h0000040, 1'b0, 0, 32'h0000_0100, 0);
        do_issue(1'b1, 2'b01, 32'h0000_0004, 26'h0,       1'b0, 5, 32'h0000_0114, 0);
        do_issue(1'b1, 2'b11, 32'hFFFF_FFFF, 26'h3FFFFFF, 1'b0, 0, 32'h0000_0000, 0);
        // redirect_valid low: PCSrc is ignored.
        do_issue(1'b0, 2'b10, 32'h0000_1234, 26'h0000055, 1'b0, 0, 32'h0000_0004, 0);
        do_issue(1'b1, 2'b10, 32'h0,         26'h3FFFFFF, 1'b0, 0, 32'h0FFF_FFFC, 0);
        // Jump region comes from PC4 (0x1000_0000), not PC.
        do_issue(1'b1, 2'b10, 32'h0,         26'h0000001, 1'b0, 0, 32'h1000_0004, 0);
        do_issue(1'b1, 2'b01, 32'h0000_0003, 26'h0,       1'b0, 0, 32'h1000_0014, 0);
        do_issue(1'b1, 2'b01, 32'hFBFF_FFF9, 26'h0,       1'b0, 0, 32'hFFFF_FFFC, 0);
        do_issue(1'b0, 2'b00, 32'h0,         26'h0,       1'b0, 0, 32'h0000_0000, 0);
        do_issue(1'b1, 2'b10, 32'h0,         26'h0000008, 1'b0, 0, 32'h0000_0020, 0);

        // Halt beats redirect at 0x20.
        do_issue(1'b1, 2'b01, 32'h0000_0010, 26'h0, 1'b1, 0, 32'h0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            #1;
            check("halt_halted", halted, 32'd1);
            check("halt_no_req", imem_req, 32'd0);
            check("halt_pc", PC, 32'h0000_0020);
            check("halt_valid", instr_valid, 32'd0);
        end

        // Asynchronous reset while waiting on a fetch at 0x40.
        do_reset();
        mem_wait = 0;
        expect_fetch(32'h0);
        do_issue(1'b1, 2'b10, 32'h0, 26'h0000010, 1'b0, 0, 32'h0000_0040, 1000);
        repeat (3) @(negedge CLK);
        #1;
        check("midwait_req", imem_req, 32'd1);
        check("midwait_pc", PC, 32'h0000_0040);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_req", imem_req, 32'd0);
        check("async_rst_pc", PC, 32'h0000_0000);
        check("async_rst_valid", instr_valid, 32'd0);
        do_reset();
        mem_wait = 0;
        expect_fetch(32'h0);
        do_issue(1'b0, 2'b00, 32'h0, 26'h0, 1'b0, 0, 32'h4, 0);
        wait_issue();
        #2;

`ifdef FETCH_TIMEOUT_EN
        // Ack never returns: timeout after four wait cycles.
        do_reset();
        mem_enable = 1'b0;
        exp_fetch.push_back(32'h0);
        begin
            int n = 0;
            while (!halted && n < 50) begin
                @(negedge CLK);
                n++;
            end
        end
        #2;
        check("to_halted", halted, 32'd1);
        check("to_fetch_err", fetch_err, 32'd1);
        check("to_req_len", 32'(last_req_len), 32'd5);
        check("to_no_req", imem_req, 32'd0);
        // Ack on the fourth wait cycle completes normally.
        do_reset();
        mem_enable = 1'b1;
        mem_wait   = 4;
        expect_fetch(32'h0);
        wait_issue();
        #2;
        check("late_ack_req_len", 32'(last_req_len), 32'd5);
        check("late_ack_fetch_err", fetch_err, 32'd0);
        check("late_ack_halted", halted, 32'd0);
`endif

        check("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
        check("issue_queue_drained", 32'(exp_issue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
